fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 48 ++++
 rtl/fetch_stage_split.sv | 41 ++++
 rtl/fetch_stage.sv | 106 ++++++++++
 tb/tb_fetch_stage.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared Y86-64 fetch definitions: instruction codes, status codes, D register layout.
package fetch_stage_pkg;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] RRMOVQ = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [3:0] AOK = 4'h1;
    localparam logic [3:0] HLT = 4'h2;
    localparam logic [3:0] ADR = 4'h3;
    localparam logic [3:0] INS = 4'h4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } d_reg_t;

    localparam d_reg_t D_BUBBLE = '{stat: AOK, icode: NOP, ifun: 4'h0,
                                    ra: RNONE, rb: RNONE, valc: 64'h0, valp: 64'h0};

    // Instruction length in bytes; unknown icodes advance by one byte.
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        case (icode)
            HALT, NOP, RET:                   instr_len = 4'd1;
            RRMOVQ, OPQ, PUSHQ, POPQ:         instr_len = 4'd2;
            JXX, CALL:                        instr_len = 4'd9;
            IRMOVQ, RMMOVQ, MRMOVQ:           instr_len = 4'd10;
            default:                          instr_len = 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/fetch_stage_split.sv
// Combinational instruction split: fields, length, constant word and next sequential PC.
module fetch_split
    import fetch_stage_pkg::*;
(
    input  logic [63:0] f_pc,
    input  logic [79:0] imem_bytes,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic        instr_valid,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [3:0]  ilen,
    output logic [63:0] valc,
    output logic [63:0] valp
);

    // Decode the opcode byte, register byte and constant word for the current PC.
    always_comb begin
        icode       = imem_bytes[7:4];
        ifun        = imem_bytes[3:0];
        instr_valid = (imem_bytes[7:4] <= POPQ);
        ilen        = instr_len(imem_bytes[7:4]);
        ra          = RNONE;
        rb          = RNONE;
        valc        = 64'h0;
        case (imem_bytes[7:4])
            RRMOVQ, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, PUSHQ, POPQ: begin
                ra = imem_bytes[15:12];
                rb = imem_bytes[11:8];
            end
            default: ;
        endcase
        case (imem_bytes[7:4])
            IRMOVQ, RMMOVQ, MRMOVQ: valc = imem_bytes[79:16];
            JXX, CALL:              valc = imem_bytes[71:8];
            default:                valc = 64'h0;
        endcase
        valp = f_pc + {60'h0, ilen};
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: decodes the instruction at f_pc, predicts the next PC and loads the D register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] f_pc,
    input  logic [79:0] imem_bytes,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    output logic [63:0] F_predPC,
    output logic [3:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP
);

    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic        instr_valid;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  ilen;
    logic [63:0] valc;
    logic [63:0] valp;

    logic        adr_err;
    d_reg_t      dec;
    d_reg_t      d_q, d_d;
    logic [63:0] pred_q, pred_d;

    fetch_split u_split (
        .f_pc        (f_pc),
        .imem_bytes  (imem_bytes),
        .icode       (icode),
        .ifun        (ifun),
        .instr_valid (instr_valid),
        .ra          (ra),
        .rb          (rb),
        .ilen        (ilen),
        .valc        (valc),
        .valp        (valp)
    );

    // Fault classification and next-state selection; the bound check is 65 bits wide so
    // a PC that wraps past 2^64 still faults instead of looking like a small address.
    always_comb begin
        adr_err = ({1'b0, f_pc} + {61'h0, ilen}) > 65'(IMEM_BYTES);

        dec.ra   = ra;
        dec.rb   = rb;
        dec.valc = valc;
        dec.valp = valp;
        if (adr_err) begin
            dec.stat  = ADR;
            dec.icode = NOP;
            dec.ifun  = 4'h0;
        end else if (!instr_valid) begin
            dec.stat  = INS;
            dec.icode = NOP;
            dec.ifun  = 4'h0;
        end else begin
            dec.stat  = (icode == HALT) ? HLT : AOK;
            dec.icode = icode;
            dec.ifun  = ifun;
        end

        pred_d = pred_q;
        if (!F_stall) begin
            pred_d = ((icode == JXX) || (icode == CALL)) ? valc : valp;
        end

        d_d = d_q;
        if (!D_stall) begin
            d_d = D_bubble ? D_BUBBLE : dec;
        end
    end

    // Pipeline registers: predicted PC and the D stage latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_q <= RESET_PC;
            d_q    <= D_BUBBLE;
        end else begin
            pred_q <= pred_d;
            d_q    <= d_d;
        end
    end

    assign F_predPC = pred_q;
    assign D_stat   = d_q.stat;
    assign D_icode  = d_q.icode;
    assign D_ifun   = d_q.ifun;
    assign D_rA     = d_q.ra;
    assign D_rB     = d_q.rb;
    assign D_valC   = d_q.valc;
    assign D_valP   = d_q.valp;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected D/predPC snapshots, a monitor compares them.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic [63:0] f_pc;
   logic [79:0] imem_bytes;
   logic        F_stall;
   logic        D_stall;
   logic        D_bubble;
   logic [63:0] F_predPC;
   logic [3:0]  D_stat;
   logic [3:0]  D_icode;
   logic [3:0]  D_ifun;
   logic [3:0]  D_rA;
   logic [3:0]  D_rB;
   logic [63:0] D_valC;
   logic [63:0] D_valP;

   fetch_stage #(.RESET_PC(64'h0), .IMEM_BYTES(1024)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .f_pc       (f_pc),
      .imem_bytes (imem_bytes),
      .F_stall    (F_stall),
      .D_stall    (D_stall),
      .D_bubble   (D_bubble),
      .F_predPC   (F_predPC),
      .D_stat     (D_stat),
      .D_icode    (D_icode),
      .D_ifun     (D_ifun),
      .D_rA       (D_rA),
      .D_rB       (D_rB),
      .D_valC     (D_valC),
      .D_valP     (D_valP)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      string       name;
      logic [3:0]  stat, icode, ifun, ra, rb;
      logic [63:0] valc, valp, pred;
   } exp_t;

   exp_t exp_q[$];
   int   n_total  = 0;
   int   n_passed = 0;
   bit   stim_done = 1'b0;

   // Monitor: at each falling edge compare every snapshot whose due cycle has arrived.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         exp_t e;
         e = exp_q.pop_front();
         n_total = n_total + 1;
         if ({D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, F_predPC} ===
             {e.stat, e.icode, e.ifun, e.ra, e.rb, e.valc, e.valp, e.pred}) begin
            n_passed = n_passed + 1;
         end else begin
            $display("FAIL %s: got stat=%h icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h pred=%h, want stat=%h icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h pred=%h",
                     e.name, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, F_predPC,
                     e.stat, e.icode, e.ifun, e.ra, e.rb, e.valc, e.valp, e.pred);
         end
      end
   end

   function automatic logic [79:0] mk(input logic [7:0] b0, input logic [7:0] b1, input logic [63:0] w);
      return {w, b1, b0};
   endfunction

   task automatic push_exp(input int due, input string nm,
                           input logic [3:0] s, input logic [3:0] ic, input logic [3:0] fn,
                           input logic [3:0] ra, input logic [3:0] rb,
                           input logic [63:0] vc, input logic [63:0] vp, input logic [63:0] pr);
      exp_t e;
      e.due = due; e.name = nm;
      e.stat = s; e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb;
      e.valc = vc; e.valp = vp; e.pred = pr;
      exp_q.push_back(e);
   endtask

   // Drive one fetch cycle; the expected snapshot is due one clock later.
   task automatic step(input string nm, input logic [63:0] pc, input logic [79:0] bytes,
                       input logic fs, input logic ds, input logic db,
                       input logic [3:0] s, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] vc, input logic [63:0] vp, input logic [63:0] pr);
      f_pc = pc; imem_bytes = bytes; F_stall = fs; D_stall = ds; D_bubble = db;
      push_exp(cyc + 1, nm, s, ic, fn, ra, rb, vc, vp, pr);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; f_pc = 64'h0; imem_bytes = 80'h0;
      F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
      push_exp(0, "reset", 4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0);
      repeat (2) @(posedge clk);
      #1;

      n_total = n_total + 1;
      if (F_predPC === 64'h0) n_passed = n_passed + 1;
      else $display("FAIL reset_pred: got %h", F_predPC);
      n_total = n_total + 1;
      if (D_icode === 4'h1) n_passed = n_passed + 1;
      else $display("FAIL reset_icode: got %h", D_icode);
      n_total = n_total + 1;
      if (D_stat === 4'h1) n_passed = n_passed + 1;
      else $display("FAIL reset_stat: got %h", D_stat);
      n_total = n_total + 1;
      if (D_rA === 4'hF) n_passed = n_passed + 1;
      else $display("FAIL reset_ra: got %h", D_rA);

      rst_n = 1'b1;

      //     name        pc                     bytes                                F  D  B   stat  icode ifun  rA    rB    valC                   valP                   predPC
      step("irmovq",   64'h10, mk(8'h30, 8'hF2, 64'h0A),             0, 0, 0, 4'h1, 4'h3, 4'h0, 4'hF, 4'h2, 64'h0A,                64'h1A,                64'h1A);
      step("call",     64'h20, mk(8'h80, 8'h00, 64'h01),             0, 0, 0, 4'h1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h100,               64'h29,                64'h100);
      step("bad_icode",64'h30, mk(8'hC0, 8'h00, 64'h0),              0, 0, 0, 4'h4, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,                 64'h31,                64'h31);
      step("adr_end",  64'h3FF, mk(8'h30, 8'hF2, 64'h0),             0, 0, 0, 4'h3, 4'h1, 4'h0, 4'hF, 4'h2, 64'h0,                 64'h409,               64'h409);
      step("halt",     64'h40, mk(8'h00, 8'h00, 64'h0),              0, 0, 0, 4'h2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0,                 64'h41,                64'h41);
      step("opq",      64'h50, mk(8'h60, 8'h23, 64'h0),              0, 0, 0, 4'h1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h0,                 64'h52,                64'h52);
      step("jxx",      64'h60, mk(8'h73, 8'h00, 64'h02),             0, 0, 0, 4'h1, 4'h7, 4'h3, 4'hF, 4'hF, 64'h200,               64'h69,                64'h200);
      step("f_stall",  64'h70, mk(8'h10, 8'h00, 64'h0),              1, 0, 0, 4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,                 64'h71,                64'h200);
      step("stall_bub",64'h80, mk(8'h90, 8'h00, 64'h0),              0, 1, 1, 4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,                 64'h71,                64'h81);
      step("bubble",   64'h90, mk(8'h20, 8'h12, 64'h0),              0, 0, 1, 4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,                 64'h0,                 64'h92);
      step("mrmovq",   64'h100, mk(8'h50, 8'h45, 64'h08),            0, 0, 0, 4'h1, 4'h5, 4'h0, 4'h4, 4'h5, 64'h08,                64'h10A,               64'h10A);
      step("adr_edge", 64'h3F6, mk(8'h30, 8'hF1, 64'hFFFFFFFFFFFFFFFF), 0, 0, 0, 4'h1, 4'h3, 4'h0, 4'hF, 4'h1, 64'hFFFFFFFFFFFFFFFF, 64'h400,         64'h400);
      step("adr_wrap", 64'hFFFFFFFFFFFFFFFF, mk(8'h10, 8'h00, 64'h0), 0, 0, 0, 4'h3, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,              64'h0,                 64'h0);
      step("ret",      64'h1A0, mk(8'h90, 8'h00, 64'h0),             0, 0, 0, 4'h1, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0,                 64'h1A1,               64'h1A1);

      // Reset between edges clears the in-flight D contents.
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      push_exp(cyc, "mid_reset", 4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      step("pushq",    64'h200, mk(8'hA0, 8'h3F, 64'h0),             0, 0, 0, 4'h1, 4'hA, 4'h0, 4'h3, 4'hF, 64'h0,                 64'h202,               64'h202);
      step("popq",     64'h202, mk(8'hB0, 8'h4F, 64'h0),             0, 0, 0, 4'h1, 4'hB, 4'h0, 4'h4, 4'hF, 64'h0,                 64'h204,               64'h204);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_total = n_total + 1;
         $display("FAIL %s: timeout, snapshot never compared (due %0d, now %0d)", e.name, e.due, cyc);
      end
      stim_done = 1'b1;
      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule
